// File: rtl/adder_sat_pkg.sv
// Shared constants and the width-generic add/saturate function used by the
// accumulator datapath. Callers zero-extend operands to MAX_W and pass their width.
package adder_sat_pkg;

  localparam int MAX_W = 64;
  localparam logic [MAX_W-1:0] SMAX = {1'b0, {(MAX_W-1){1'b1}}};
  localparam logic [MAX_W-1:0] SMIN = {1'b1, {(MAX_W-1){1'b0}}};

  // Returns {ovf, result}; only the low w bits of result are meaningful.
  // Bit positions are selected with masks so w can be any value 2..MAX_W.
  function automatic logic [MAX_W:0] sat_add(
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input int               w,
    input logic             is_signed,
    input logic             sat_en
  );
    logic [MAX_W-1:0] mask, msb, res;
    logic [MAX_W:0]   ax, bx, s, carry_bit;
    logic             sa, sb, ovf;
    mask      = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    msb       = mask ^ (mask >> 1);
    carry_bit = {1'b0, mask} + {{MAX_W{1'b0}}, 1'b1};
    sa        = is_signed & (|(a & msb));
    sb        = is_signed & (|(b & msb));
    ax        = {sa, (a & mask) | (sa ? ~mask : '0)};
    bx        = {sb, (b & mask) | (sb ? ~mask : '0)};
    s         = ax + bx;
    if (is_signed) ovf = (|(s & carry_bit)) != (|(s[MAX_W-1:0] & msb));
    else           ovf = |(s & carry_bit);
    res = s[MAX_W-1:0] & mask;
    if (ovf && sat_en) begin
      if (is_signed) res = sb ? (SMIN >> (MAX_W - w)) : (SMAX >> (MAX_W - w));
      else           res = mask;
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/adder_sat_core.sv
// Combinational saturating/wrapping adder with overflow flag, WIDTH/SIGNED
// parametrised wrapper around the package function.
module adder_sat_core
  import adder_sat_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sat_en,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  logic [MAX_W:0] r;

  assign r      = sat_add(MAX_W'(a), MAX_W'(b), WIDTH, SIGNED, sat_en);
  assign result = r[WIDTH-1:0];
  assign ovf    = r[MAX_W];

  generate
    if (WIDTH < MAX_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^r[MAX_W-1:WIDTH];
    end
  endgenerate

endmodule

// File: rtl/adder_sat_accum.sv
// Multi-channel frame accumulator: per-channel running sum plus sticky overflow,
// frame total emitted on a registered valid/ready output on the last beat.
module adder_sat_accum
  import adder_sat_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NCH    = 4,
  parameter  int SIGNED = 1,
  localparam int CHW    = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sat_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CHW-1:0]   in_ch,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CHW-1:0]   out_ch,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  logic [NCH-1:0][WIDTH-1:0] acc_q, acc_d;
  logic [NCH-1:0]            ovf_q, ovf_d;
  logic                      out_valid_q, out_valid_d;
  logic [CHW-1:0]            out_ch_q, out_ch_d;
  logic [WIDTH-1:0]          out_data_q, out_data_d;
  logic                      out_ovf_q, out_ovf_d;

  logic             accept;
  logic [WIDTH-1:0] op_a, sum_res;
  logic             sum_ovf, new_ovf;

  // Ready is forced high in reset so upstream never sees a stall from stale state.
  assign in_ready = !rst_n || !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign op_a     = in_first ? '0 : acc_q[in_ch];
  assign new_ovf  = (!in_first && ovf_q[in_ch]) || sum_ovf;

  adder_sat_core #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED != 0)
  ) u_core (
    .a      (op_a),
    .b      (in_data),
    .sat_en (sat_en),
    .result (sum_res),
    .ovf    (sum_ovf)
  );

  always_comb begin
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (accept && in_last) begin
      acc_d[in_ch] = '0;
      ovf_d[in_ch] = 1'b0;
      out_valid_d  = 1'b1;
      out_ch_d     = in_ch;
      out_data_d   = sum_res;
      out_ovf_d    = new_ovf;
    end else begin
      if (accept) begin
        acc_d[in_ch] = sum_res;
        ovf_d[in_ch] = new_ovf;
      end
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: doc/adder_sat_accum.md
# adder_sat_accum

Parametrised, multi-channel accumulator with a valid/ready handshake.
- Each input beat is added into a per-channel running sum, in signed or unsigned arithmetic.
- Each add either saturates or wraps, selected at run time.
- On the last beat of a frame, the frame total and a sticky overflow flag are emitted on a registered output.
- It is the sequential successor of the combinational adder/saturating-adder pair and sits between C-model-verified datapath stages in C2RTL flows.

## Interface
Parameters:
- WIDTH, 32, data/accumulator width in bits (≥2)
- NCH, 4, number of independent channels (power of two, ≥2)
- SIGNED, 1, 1 = two's-complement arithmetic, 0 = unsigned
- CHW, $clog2(NCH), channel index width (derived, not overridden)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- sat_en  in  1  1 = saturate on overflow, 0 = wrap (sampled per accepted beat)
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept beat
- in_ch  in  CHW  channel of beat
- in_data  in  WIDTH  addend
- in_first  in  1  beat starts a new frame: treat old accumulator as 0 and clear flag
- in_last  in  1  beat ends frame: emit result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_ch  out  CHW  channel of result
- out_data  out  WIDTH  frame total
- out_ovf  out  1  an overflow occurred on any beat of the frame

## Operation
- Accept: beat accepted when in_valid && in_ready.
- Per-channel state: acc[NCH] (WIDTH bits) and ovf[NCH] (1 bit).
- Operand A = in_first ? 0 : acc[in_ch]; operand B = in_data.
- Sum is computed at WIDTH+1 bits:
  - SIGNED: sign-extend both operands; overflow when sum[WIDTH] != sum[WIDTH-1].
  - Unsigned: zero-extend both operands; overflow when sum[WIDTH] = 1.
- Result when overflow and sat_en = 1:
  - SIGNED: 2^(W-1)-1 if B ≥ 0, else -2^(W-1).
  - Unsigned: all-ones.
- Result when overflow and sat_en = 0: sum[WIDTH-1:0].
- Flag: new_ovf = (in_first ? 0 : ovf[in_ch]) | overflow. Overflow is flagged in both modes.
- Non-last beat: acc[in_ch] ← result, ovf[in_ch] ← new_ovf. No output.
- Last beat:
  - Output register ← {in_ch, result, new_ovf}, and out_valid ← 1.
  - acc[in_ch] ← 0 and ovf[in_ch] ← 0, so the next frame starts clean even without in_first.
- in_first && in_last on the same beat: a single-beat frame. out_data = in_data, out_ovf = 0.
- Other channels are never disturbed by a beat.

## Timing
- Reset (rst_n = 0 at a rising edge) forces:
  - all acc = 0 and all ovf = 0;
  - out_valid = 0, out_data = 0, out_ch = 0, out_ovf = 0.
- in_ready = 1 during reset.
- Reset mid-frame discards all partial sums and any pending result.
- Throughput is one beat per cycle, including back-to-back beats on the same channel. The updated acc is visible to the next cycle's beat with no bypass hazard, because acc is read combinationally from registers.
- Latency: accepted last beat at edge N → out_valid = 1 after edge N, until handshake.
- in_ready = !out_valid || out_ready (combinational; no skid buffer).
- Output stall: while out_valid && !out_ready:
  - in_ready = 0 and no state changes;
  - out_ch, out_data and out_ovf are held stable.
- out_valid && out_ready with a new last beat accepted in the same cycle: the output register is reloaded and out_valid stays 1, with no bubble.
- out_valid && out_ready with no last beat: out_valid → 0 next cycle. out_data keeps its stale value.
- sat_en may change between beats. Each beat uses its own sampled value.

## Structure
- Package adder_sat_pkg holds:
  - function sat_add(a, b, is_signed, sat_en) returning {ovf, result[WIDTH-1:0]}, parametrised by width through the caller;
  - localparams for signed max/min constants.
- Sub-module adder_sat_core: a combinational, WIDTH/SIGNED-parametrised saturating/wrapping adder with overflow output, instantiated once on the accept path.
- Top holds the acc/ovf arrays, the output register and the handshake.

## Test plan
- WIDTH=8, SIGNED=1, sat_en=1, ch0: beats 100(first), 50(last) → out_data=127, out_ovf=1, out_ch=0, one cycle after the last beat.
- WIDTH=8, SIGNED=1, sat_en=0, ch1: beats -100(first), -50(last) → out_data=106, out_ovf=1. Then a single beat 5(first, last) → out_data=5, out_ovf=0.
- WIDTH=8, SIGNED=0, sat_en=1, ch2: beats 200, 100(last) → out_data=255, out_ovf=1. A following frame of 1, 2(last) → out_data=3, out_ovf=0 (auto-clear after last).
- Interleave: ch0 +3, ch1 +10, ch0 +4(last), ch1 +20(last), back-to-back → results (ch0, 7) then (ch1, 30), no cross-channel corruption.
- Back-pressure: hold out_ready=0 with a result pending → in_ready=0 and the output is stable for 5 cycles. Release out_ready in the same cycle as a new last beat → the new result appears next cycle and out_valid never drops.
- Reset: assert rst_n=0 mid-frame on ch3 after beats 40, 40 → all outputs 0. A post-reset frame 1(last) on ch3 → out_data=1.
